// File: rtl/uart_dumper_pkg.sv
// Shared types and sizing for the program-memory readback engine.
// The shared defines header normally provides COMMAND_WIDTH / PROGRAM_MEM_SIZE; the fallbacks apply only when it was not included first.
`ifndef COMMAND_WIDTH
`define COMMAND_WIDTH 32
`endif
`ifndef PROGRAM_MEM_SIZE
`define PROGRAM_MEM_SIZE 16
`endif

package uart_dumper_pkg;

  localparam int CMD_W    = `COMMAND_WIDTH;
  localparam int MEM_SIZE = `PROGRAM_MEM_SIZE;
  localparam int ADDR_W   = $clog2(MEM_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_NEXT      = 3'd5,
    ST_TERM      = 3'd6,
    ST_DONE      = 3'd7
  } dump_state_t;

  function automatic logic is_all_ones(input logic [CMD_W-1:0] word);
    return &word;
  endfunction

endpackage

// File: rtl/uart_dumper.sv
// Halts the CPU, reads program memory from address 0 upward and streams each
// word MSB byte first to the UART transmitter, followed by an all-ones terminator.
module uart_dumper
  import uart_dumper_pkg::*;
#(
  parameter int TX_DATA_WIDTH      = 8,
  parameter bit STOP_ON_TERMINATOR = 1'b0
) (
  input  logic                     CLK_100MHz_in,
  input  logic                     rst_n_in,
  input  logic                     dump_start_in,
  input  logic                     uart_tx_ready_in,
  output logic                     uart_transmit_reg_out,
  output logic [TX_DATA_WIDTH-1:0] uart_txdata_reg_out,
  output logic                     dump_mem_rd_reg_out,
  output logic [ADDR_W-1:0]        dump_mem_addr_reg_out,
  input  logic [CMD_W-1:0]         mem_rdata_in,
  output logic                     cpu_halt_reg_out,
  output logic                     dump_done_reg_out
);

  localparam int BYTES = CMD_W / TX_DATA_WIDTH;
  localparam int CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] BYTES_CNT = CNT_W'(BYTES);

  dump_state_t              state, state_nxt;
  logic [CMD_W-1:0]         shift_reg, shift_nxt;
  logic [CNT_W-1:0]         byte_cnt, cnt_nxt;
  logic                     term_sent, term_nxt;
  logic                     transmit_nxt, rd_nxt, halt_nxt, done_nxt;
  logic [TX_DATA_WIDTH-1:0] txdata_nxt;
  logic [ADDR_W-1:0]        addr_nxt;

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge CLK_100MHz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                 <= ST_IDLE;
      shift_reg             <= '0;
      byte_cnt              <= '0;
      term_sent             <= 1'b0;
      uart_transmit_reg_out <= 1'b0;
      uart_txdata_reg_out   <= '0;
      dump_mem_rd_reg_out   <= 1'b0;
      dump_mem_addr_reg_out <= '0;
      cpu_halt_reg_out      <= 1'b0;
      dump_done_reg_out     <= 1'b0;
    end else begin
      state                 <= state_nxt;
      shift_reg             <= shift_nxt;
      byte_cnt              <= cnt_nxt;
      term_sent             <= term_nxt;
      uart_transmit_reg_out <= transmit_nxt;
      uart_txdata_reg_out   <= txdata_nxt;
      dump_mem_rd_reg_out   <= rd_nxt;
      dump_mem_addr_reg_out <= addr_nxt;
      cpu_halt_reg_out      <= halt_nxt;
      dump_done_reg_out     <= done_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    cnt_nxt      = byte_cnt;
    term_nxt     = term_sent;
    transmit_nxt = 1'b0;
    txdata_nxt   = uart_txdata_reg_out;
    rd_nxt       = 1'b0;
    addr_nxt     = dump_mem_addr_reg_out;
    halt_nxt     = cpu_halt_reg_out;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_start_in) begin
          halt_nxt  = 1'b1;
          addr_nxt  = '0;
          rd_nxt    = 1'b1;
          term_nxt  = 1'b0;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: state_nxt = ST_LOAD;
      ST_LOAD: begin
        shift_nxt = mem_rdata_in;
        cnt_nxt   = '0;
        // A stored all-ones word doubles as the terminator in stop mode.
        if (STOP_ON_TERMINATOR && is_all_ones(mem_rdata_in)) begin
          term_nxt = 1'b1;
        end else begin
          term_nxt = term_sent;
        end
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (uart_tx_ready_in) begin
          txdata_nxt   = shift_reg[CMD_W-1 -: TX_DATA_WIDTH];
          transmit_nxt = 1'b1;
          shift_nxt    = shift_reg << TX_DATA_WIDTH;
          cnt_nxt      = byte_cnt + CNT_W'(1);
          state_nxt    = ST_WAIT_BUSY;
        end else begin
          state_nxt = ST_SEND;
        end
      end
      ST_WAIT_BUSY: begin
        if (!uart_tx_ready_in) begin
          if (byte_cnt < BYTES_CNT) begin
            state_nxt = ST_SEND;
          end else begin
            state_nxt = ST_NEXT;
          end
        end else begin
          state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_NEXT: begin
        if (term_sent || (&dump_mem_addr_reg_out)) begin
          state_nxt = ST_TERM;
        end else begin
          addr_nxt  = dump_mem_addr_reg_out + ADDR_W'(1);
          rd_nxt    = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_TERM: begin
        if (term_sent) begin
          state_nxt = ST_DONE;
        end else begin
          shift_nxt = '1;
          cnt_nxt   = '0;
          term_nxt  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        halt_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        halt_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_dumper.sv
// Randomized bench: two dumpers (stop mode off/on) share one memory image and
// are checked against a byte-stream model computed directly from that image.
module tb_uart_dumper;
  import uart_dumper_pkg::*;

  localparam int TXW   = 8;
  localparam int BYTES = CMD_W / TXW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, hold;
  logic ready_a, ready_b, transmit_a, transmit_b, rd_a, rd_b;
  logic halt_a, halt_b, done_a, done_b;
  logic [TXW-1:0] txdata_a, txdata_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [CMD_W-1:0] rdata_a, rdata_b;
  logic [CMD_W-1:0] mem [MEM_SIZE];
  int unsigned txlen = 3;
  int busy_a, busy_b;
  int cyc = 0;

  uart_dumper #(.TX_DATA_WIDTH(TXW), .STOP_ON_TERMINATOR(1'b0)) dut_a (
    .CLK_100MHz_in(clk), .rst_n_in(rst_n), .dump_start_in(start_a),
    .uart_tx_ready_in(ready_a), .uart_transmit_reg_out(transmit_a),
    .uart_txdata_reg_out(txdata_a), .dump_mem_rd_reg_out(rd_a),
    .dump_mem_addr_reg_out(addr_a), .mem_rdata_in(rdata_a),
    .cpu_halt_reg_out(halt_a), .dump_done_reg_out(done_a));

  uart_dumper #(.TX_DATA_WIDTH(TXW), .STOP_ON_TERMINATOR(1'b1)) dut_b (
    .CLK_100MHz_in(clk), .rst_n_in(rst_n), .dump_start_in(start_b),
    .uart_tx_ready_in(ready_b), .uart_transmit_reg_out(transmit_b),
    .uart_txdata_reg_out(txdata_b), .dump_mem_rd_reg_out(rd_b),
    .dump_mem_addr_reg_out(addr_b), .mem_rdata_in(rdata_b),
    .cpu_halt_reg_out(halt_b), .dump_done_reg_out(done_b));

  // Transmitter models: busy for txlen cycles after each accepted byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_a <= 0;
      busy_b <= 0;
    end else begin
      busy_a <= transmit_a ? int'(txlen) : (busy_a > 0 ? busy_a - 1 : 0);
      busy_b <= transmit_b ? int'(txlen) : (busy_b > 0 ? busy_b - 1 : 0);
    end
  end
  assign ready_a = (busy_a == 0) && !hold;
  assign ready_b = (busy_b == 0) && !hold;

  // Synchronous-read program memory, one read port per dumper.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_a) rdata_a <= mem[addr_a];
    if (rd_b) rdata_b <= mem[addr_b];
  end

  logic [TXW-1:0] q_a[$], q_b[$], exp_a[$], exp_b[$];
  int strobe_cyc_a[$], halt_rise_a[$];
  int done_cnt_a = 0, done_cnt_b = 0, rd_cnt_b = 0, halt_bad = 0, done_bad = 0, hold_strobes = 0;
  logic [ADDR_W-1:0] last_addr_b = '0;
  logic halt_a_prev = 1'b0;

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    halt_a_prev <= halt_a;
    if (halt_a && !halt_a_prev) halt_rise_a.push_back(cyc);
    if (transmit_a) begin
      q_a.push_back(txdata_a);
      strobe_cyc_a.push_back(cyc);
      if (!halt_a) halt_bad <= halt_bad + 1;
    end
    if (transmit_b) begin
      q_b.push_back(txdata_b);
      if (!halt_b) halt_bad <= halt_bad + 1;
    end
    if ((transmit_a || transmit_b) && hold) hold_strobes <= hold_strobes + 1;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      if (halt_a) done_bad <= done_bad + 1;
    end
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      if (halt_b) done_bad <= done_bad + 1;
    end
    if (rd_b) begin
      rd_cnt_b    <= rd_cnt_b + 1;
      last_addr_b <= addr_b;
    end
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int exp_reads_b, exp_last_b;

  // Reference: full memory plus terminator for A; B stops after the first all-ones word.
  task automatic build_expected();
    bit stopped = 1'b0;
    logic [CMD_W-1:0] w;
    exp_a.delete();
    exp_b.delete();
    exp_reads_b = MEM_SIZE;
    exp_last_b  = MEM_SIZE - 1;
    for (int i = 0; i < MEM_SIZE; i++) begin
      w = mem[i];
      for (int b = 0; b < BYTES; b++) begin
        exp_a.push_back(TXW'((w >> (TXW * (BYTES - 1 - b))) & 'hFF));
        if (!stopped) exp_b.push_back(TXW'((w >> (TXW * (BYTES - 1 - b))) & 'hFF));
      end
      if (!stopped && w == {CMD_W{1'b1}}) begin
        stopped     = 1'b1;
        exp_reads_b = i + 1;
        exp_last_b  = i;
      end
    end
    for (int b = 0; b < BYTES; b++) begin
      exp_a.push_back(8'hFF);
      if (!stopped) exp_b.push_back(8'hFF);
    end
  endtask

  task automatic run_dump(input string name, input bit go_b, input bit pulse, input int stall_at);
    int base_a = q_a.size(), base_b = q_b.size();
    int da = done_cnt_a, db = done_cnt_b, rdb = rd_cnt_b;
    int hb = halt_bad, dbad = done_bad, hs = hold_strobes;
    int sb = strobe_cyc_a.size(), hrb = halt_rise_a.size();
    int s;
    bit finished = 1'b0, stalled = 1'b0;
    build_expected();
    @(negedge clk); #1;
    start_a = 1'b1; start_b = go_b; s = cyc;
    @(negedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if (stall_at > 0 && !stalled && q_a.size() - base_a >= stall_at) begin
        hold = 1'b1;
        repeat (100) @(negedge clk);
        #1 hold = 1'b0;
        stalled = 1'b1;
      end
      if (pulse && (n % 23 == 5) && halt_a) begin
        start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
      end
      if (done_cnt_a > da && (!go_b || done_cnt_b > db)) begin
        finished = 1'b1;
        break;
      end
    end
    check_eq({name, "_finished"}, 64'(finished), 64'd1);
    repeat (30) @(negedge clk);
    #1;
    check_eq({name, "_a_len"}, 64'(q_a.size() - base_a), 64'(exp_a.size()));
    foreach (exp_a[i])
      check_eq($sformatf("%s_a_byte%0d", name, i),
               (base_a + i < q_a.size()) ? 64'(q_a[base_a + i]) : 64'h100, 64'(exp_a[i]));
    check_eq({name, "_a_done"}, 64'(done_cnt_a - da), 64'd1);
    check_eq({name, "_halt_rise"}, (halt_rise_a.size() > hrb) ? 64'(halt_rise_a[hrb] - s) : 64'hFFFF, 64'd1);
    check_eq({name, "_first_strobe"}, (strobe_cyc_a.size() > sb) ? 64'(strobe_cyc_a[sb] - s) : 64'hFFFF, 64'd4);
    check_eq({name, "_halt_bad"}, 64'(halt_bad - hb), 64'd0);
    check_eq({name, "_done_bad"}, 64'(done_bad - dbad), 64'd0);
    check_eq({name, "_halt_end"}, 64'(halt_a), 64'd0);
    check_eq({name, "_hold_strobes"}, 64'(hold_strobes - hs), 64'd0);
    if (go_b) begin
      check_eq({name, "_b_len"}, 64'(q_b.size() - base_b), 64'(exp_b.size()));
      foreach (exp_b[i])
        check_eq($sformatf("%s_b_byte%0d", name, i),
                 (base_b + i < q_b.size()) ? 64'(q_b[base_b + i]) : 64'h100, 64'(exp_b[i]));
      check_eq({name, "_b_done"}, 64'(done_cnt_b - db), 64'd1);
      check_eq({name, "_b_reads"}, 64'(rd_cnt_b - rdb), 64'(exp_reads_b));
      check_eq({name, "_b_last_addr"}, 64'(last_addr_b), 64'(exp_last_b));
    end
  endtask

  task automatic fill_incrementing();
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 32'h11223300 + CMD_W'(i);
  endtask

  initial begin
    int ones_at, base;
    bit got10;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; hold = 1'b0;
    fill_incrementing();
    repeat (3) @(negedge clk);
    check_eq("rst_outs_a", {txdata_a, transmit_a, rd_a, addr_a, halt_a, done_a}, 64'd0);
    check_eq("rst_outs_b", {txdata_b, transmit_b, rd_b, addr_b, halt_b, done_b}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_halt", 64'(halt_a | halt_b), 64'd0);

    run_dump("incr", 1'b1, 1'b0, 0);
    mem[5] = '1;
    run_dump("ones5", 1'b1, 1'b1, 0);
    run_dump("stall", 1'b1, 1'b0, 6);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = CMD_W'($urandom);
      ones_at = int'($urandom_range(0, MEM_SIZE));
      if (ones_at < MEM_SIZE) mem[ones_at] = '1;
      txlen = $urandom_range(1, 4);
      run_dump($sformatf("rand%0d", r), 1'b1, 1'($urandom_range(0, 1)), 0);
    end

    // Asynchronous reset after the 10th byte, then a clean restart.
    fill_incrementing();
    txlen = 3;
    base = q_a.size();
    got10 = 1'b0;
    @(negedge clk); #1 start_a = 1'b1;
    @(negedge clk); #1 start_a = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk); #1;
      if (q_a.size() - base >= 10) begin
        got10 = 1'b1;
        break;
      end
    end
    check_eq("rst_reach10", 64'(got10), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {txdata_a, transmit_a, rd_a, addr_a, done_a}, 64'd0);
    check_eq("async_rst_halt", 64'(halt_a), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_dump("restart", 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_dumper.md
# uart_dumper

Program-memory readback engine, the reverse path of the UART flash loader. On a start pulse it halts the CPU, reads every program-memory word from address 0 upward and streams each one out through the UART transmitter as `COMMAND_WIDTH/TX_DATA_WIDTH` bytes, MSB byte first. It then appends an all-ones terminator word. The resulting byte stream can be replayed verbatim into the flash loader.

## Interface
Parameters:
- TX_DATA_WIDTH, 8, UART byte width; `COMMAND_WIDTH` must be an integer multiple of it.
- STOP_ON_TERMINATOR, 0
  - 1: stop after transmitting the first stored all-ones word.
  - 0: dump the whole memory, then append the terminator.

Ports:
- CLK_100MHz_in  in  1  system clock.
- rst_n_in  in  1  reset. One clock; reset is asynchronous and active-low.
- dump_start_in  in  1  start request. Sampled only in IDLE.
- uart_tx_ready_in  in  1  transmitter idle. It deasserts the cycle after a byte is accepted.
- uart_transmit_reg_out  out  1  one-cycle byte-send strobe.
- uart_txdata_reg_out  out  TX_DATA_WIDTH  byte to send. Valid while the strobe is high.
- dump_mem_rd_reg_out  out  1  memory read enable.
- dump_mem_addr_reg_out  out  $clog2(`PROGRAM_MEM_SIZE)  read address.
- mem_rdata_in  in  `COMMAND_WIDTH`  synchronous-read data. Valid one cycle after the read enable.
- cpu_halt_reg_out  out  1  holds the CPU stopped during a dump.
- dump_done_reg_out  out  1  one-cycle pulse when the dump completes.

## Operation
- Derived constants:
  - BYTES = `COMMAND_WIDTH/TX_DATA_WIDTH`.
  - Byte counter width is $clog2(BYTES)+1.
  - The address is a plain binary up-counter.
- States and transitions:
  - IDLE: when dump_start_in=1, set cpu_halt=1, addr=0, rd=1, and go to READ.
  - READ: set rd=0 and go to LOAD.
  - LOAD: shift_reg<=mem_rdata_in, byte_cnt<=0, go to SEND.
  - SEND: if uart_tx_ready_in=1, drive txdata<=shift_reg[MSB byte] and transmit<=1, shift left by TX_DATA_WIDTH, byte_cnt++, then go to WAIT_BUSY.
  - WAIT_BUSY: transmit<=0. Stay until uart_tx_ready_in=0, then:
    - byte_cnt<BYTES: go to SEND.
    - Otherwise: go to NEXT.
  - NEXT: go to TERM if any of these holds:
    - the word just sent was the terminator;
    - STOP_ON_TERMINATOR=1 and the word was all-ones;
    - addr is all-ones (last address).
    Otherwise addr++, rd=1, go to READ.
  - TERM:
    - If the terminator was already sent: go to DONE.
    - Otherwise load shift_reg with all-ones, byte_cnt=0, mark terminator sent, go to SEND.
  - DONE: pulse dump_done=1, set cpu_halt=0, go to IDLE.
- Word count:
  - STOP_ON_TERMINATOR=0: always `PROGRAM_MEM_SIZE`+1 words, i.e. (`PROGRAM_MEM_SIZE`+1)*BYTES bytes. Stored all-ones words are sent as data.
  - STOP_ON_TERMINATOR=1: the stored all-ones word itself serves as the terminator. Nothing is appended after it.
- Boundary conditions:
  - dump_start_in outside IDLE is ignored. No queuing.
  - The address never wraps. The last-address check in NEXT prevents the increment.
  - Reset mid-dump clears all state and outputs immediately, including releasing cpu_halt. A partially sent word is not resumed.
  - uart_tx_ready_in held low stalls in SEND indefinitely. There is no timeout.

## Timing
- Reset values: every output and internal register is 0; state is IDLE.
- With start sampled high at edge 0 and uart_tx_ready_in=1:
  - cpu_halt and rd are high after edge 1.
  - Data is captured at edge 3.
  - The first transmit strobe is high after edge 4.
- Byte spacing is bounded by the transmitter. The minimum is 2 cycles (SEND, WAIT_BUSY) per byte when ready drops immediately.
- Word overhead is 3 cycles (NEXT, READ, LOAD) between the last byte of one word and the first SEND of the next.
- dump_done is exactly one cycle long. It coincides with cpu_halt falling.
- rd is exactly one cycle per word. The address is stable from the rd cycle through LOAD.

## Structure
- `COMMAND_WIDTH` and `PROGRAM_MEM_SIZE` come from the shared defines header already used by the loader.
- The state encoding localparams are local to the block.
- No sub-module is required. Optional: factor the byte serializer (shift register + byte_cnt + SEND/WAIT_BUSY handshake) into `uart_word_serializer`, reusable for other word-to-byte paths.

## Test plan
Bench setup: `COMMAND_WIDTH`=32, `PROGRAM_MEM_SIZE`=16, TX_DATA_WIDTH=8.
- Memory word i = 0x11223300+i, STOP_ON_TERMINATOR=0, ideal transmitter (ready low 3 cycles after each strobe) -> 68 bytes: 11 22 33 00, 11 22 33 01, …, 11 22 33 0F, then FF FF FF FF. A single dump_done pulse follows, with cpu_halt high throughout.
- Word 5 = 0xFFFFFFFF, STOP_ON_TERMINATOR=1 -> exactly 24 bytes ending FF FF FF FF. No further reads after address 5; done asserts.
- Same memory, STOP_ON_TERMINATOR=0 -> word 5 is sent as data and the dump continues to 68 bytes.
- Hold uart_tx_ready_in low for 100 cycles mid-word -> no strobe while low, no byte lost or duplicated, data order intact.
- Pulse dump_start_in repeatedly during a dump -> ignored, byte count unchanged.
- Assert rst_n_in low after the 10th byte -> all outputs 0 asynchronously. A new start restarts at address 0, byte 0x11.
